uart_rx: RTL and testbench
==========================

# uart_rx

UART receive stage of the thermometer's serial link. It sits directly downstream of the baud rate generator and consumes its 16x-oversampling `sample_tick` to recover 8N1 frames from the asynchronous `rx` line. Each received byte is presented with a one-cycle done strobe and a framing-error flag. The byte is consumed by the command/readout logic.

## Interface
Parameters:
- `DBIT`, 8: data bits per frame, LSB first.
- `SB_TICK`, 16: sample ticks spanning the stop bit. Use 16 for 1 stop bit.

Ports:
- `clk`  in  1  system clock; the single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `rx`  in  1  asynchronous serial line; idles high.
- `s_tick`  in  1  oversampling tick from the baud rate generator; one clk-cycle pulse at 16x baud.
- `dout`  out  DBIT  last received data byte.
- `rx_done_tick`  out  1  one-cycle strobe: a frame has completed and `dout` has been updated.
- `frame_err`  out  1  stop bit of the last frame was sampled low; valid with `rx_done_tick`, held until the next frame.

## Operation
- **Input synchronizer.** `rx` passes through a 2-flop synchronizer, whose output is `rx_s`. Both flops reset to 1. All FSM decisions use `rx_s` only.
- **Counters.**
  - Sample counter `s`: 4 bits. It wraps only under FSM control and never free-runs.
  - Bit counter `n`: clog2(DBIT) bits.
  - Shift register `b`: DBIT bits.
- **FSM states:** IDLE, START, DATA, STOP.
- **IDLE:**
  - On `rx_s`==0, go to START with `s`=0.
  - `s_tick` is not needed to leave IDLE.
- **START** (advances only on `s_tick`):
  - On `s_tick` with `s`==7 (mid start bit):
    - If `rx_s`==0: go to DATA with `s`=0 and `n`=0.
    - If `rx_s`==1: go back to IDLE. This is glitch rejection, and no strobe is issued.
  - On any other `s_tick`: `s`+1.
- **DATA:**
  - On `s_tick` with `s`==15 (mid data bit): `b` = {`rx_s`, `b`[DBIT-1:1]} and `s`=0.
    - If `n`==DBIT-1, go to STOP.
    - Otherwise `n`+1.
  - On any other `s_tick`: `s`+1.
- **STOP:**
  - On `s_tick` with `s`==SB_TICK-1:
    - `dout` = `b` and `frame_err` = ~`rx_s`.
    - `rx_done_tick` = 1 for one cycle.
    - Go to IDLE.
  - On any other `s_tick`: `s`+1.
- **Ticks and registration.**
  - Cycles without `s_tick` hold all state in START, DATA and STOP.
  - All outputs are registered.
  - `dout` and `frame_err` change only when `rx_done_tick` fires.
- **Framing error.** The byte is still delivered when `frame_err`=1; the consumer decides whether to discard it.
- **Break condition** (`rx` held low): produces a frame with `dout`=0 and `frame_err`=1. The FSM then re-enters START immediately because the line is still low. This is accepted behaviour.
- **Reset** (synchronous; wins over every other event, including mid-frame):
  - State goes to IDLE; `s`, `n`, `b`, `dout`, `frame_err` and `rx_done_tick` go to 0; synchronizer flops go to 1.
  - Any partial frame is discarded.

## Timing
- **Start detection.** A falling edge on `rx` is seen at the FSM two cycles later (synchronizer latency). START is entered on the following clk edge.
- **Sampling points** (ticks counted from START entry):
  - Start bit is checked at tick 8.
  - Data bit k is sampled 16 ticks later than bit k-1; bit 0 is sampled at tick 24.
  - Stop bit is sampled at tick 24 + 16·(DBIT-1) + SB_TICK = 152 for the defaults.
  - Every sample lands within ±1 tick of bit centre.
- **Done strobe.** `rx_done_tick` is high for exactly the one clk cycle after the clk edge on which the final stop-bit `s_tick` is consumed. `dout` and `frame_err` become valid in that same cycle.
- **Back-to-back frames.** IDLE is reached half a bit before the true end of the stop bit, so a start bit immediately following the stop bit is never missed.
- **Throughput.** One byte per (1+DBIT+1) bit times.

## Test plan
- **Single byte.** Clock 50 MHz, baud generator dvsr=162 (one tick per 163 clk). Drive 0x55, 8N1, at 19200 baud. Required: exactly one `rx_done_tick` pulse, `dout`=0x55, `frame_err`=0, and the strobe width is 1 cycle.
- **Back-to-back.** Send 0xA3 then 0x0F with no idle gap. Required: two strobes about 10 bit times apart, carrying `dout`=0xA3 then 0x0F, and no lost or merged frames.
- **Start glitch.** Pull `rx` low for 3 tick periods, then release high. Required: the FSM returns to IDLE, no `rx_done_tick`, and `dout` is unchanged.
- **Framing error.** Send 0xC8 with the stop bit driven low. Required: `rx_done_tick` pulses with `dout`=0xC8 and `frame_err`=1. A subsequent valid 0x21 then clears `frame_err` to 0.
- **Reset mid-frame.** Assert `reset` for 1 cycle during data bit 4 of 0xFF. Required: all outputs 0 on the next cycle and no strobe for the aborted frame. A following clean 0x7E is received correctly.
- **Tick gating.** Hold `s_tick`=0 for 1000 cycles mid-frame, then resume. Required: state and counters are frozen, and the byte completes correctly once ticks resume.

Source files
------------

// File: rtl/uart_rx.sv
// UART 8N1 receiver: recovers frames from the asynchronous rx line using the
// 16x oversampling tick, presenting each byte with a done strobe and framing flag.
module uart_rx #(
    parameter int unsigned DBIT    = 8,
    parameter int unsigned SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    input  logic            s_tick,
    output logic [DBIT-1:0] dout,
    output logic            rx_done_tick,
    output logic            frame_err
);

    localparam int unsigned NW = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam logic [3:0]    S_MID_START = 4'd7;
    localparam logic [3:0]    S_MID_DATA  = 4'd15;
    localparam logic [3:0]    S_STOP_LAST = 4'(SB_TICK - 1);
    localparam logic [NW-1:0] N_LAST      = NW'(DBIT - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    state_e          state_q, state_d;
    logic [3:0]      s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] b_q, b_d;
    logic [DBIT-1:0] dout_q, dout_d;
    logic            frame_err_q, frame_err_d;
    logic            done_q, done_d;
    logic            rx_meta_q, rx_s_q;

    // Two-flop synchronizer; idles high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            s_q         <= '0;
            n_q         <= '0;
            b_q         <= '0;
            dout_q      <= '0;
            frame_err_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            s_q         <= s_d;
            n_q         <= n_d;
            b_q         <= b_d;
            dout_q      <= dout_d;
            frame_err_q <= frame_err_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        n_d         = n_q;
        b_d         = b_q;
        dout_d      = dout_q;
        frame_err_d = frame_err_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    s_d     = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_q == S_MID_START) begin
                        // A line that is high again at mid start bit was a glitch.
                        if (!rx_s_q) begin
                            state_d = DATA;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_q == S_MID_DATA) begin
                        b_d = {rx_s_q, b_q[DBIT-1:1]};
                        s_d = '0;
                        if (n_q == N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_d = n_q + NW'(1);
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_q == S_STOP_LAST) begin
                        dout_d      = b_q;
                        frame_err_d = ~rx_s_q;
                        done_d      = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign dout         = dout_q;
    assign frame_err    = frame_err_q;
    assign rx_done_tick = done_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized bench for uart_rx; the line is driven in tick units and
// every delivered frame is compared against the byte and stop level that were sent.
module tb_uart_rx;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       rx     = 1'b1;
    logic       s_tick = 1'b0;
    logic [7:0] dout;
    logic       rx_done_tick;
    logic       frame_err;

    uart_rx #(.DBIT(8), .SB_TICK(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx           (rx),
        .s_tick       (s_tick),
        .dout         (dout),
        .rx_done_tick (rx_done_tick),
        .frame_err    (frame_err)
    );

    always #10 clk = ~clk;

    // Baud tick generator: one pulse every dvsr+1 clocks, gateable.
    int unsigned dvsr    = 3;
    bit          tick_en = 1'b1;
    int unsigned tcnt    = 0;
    longint      cyc     = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tcnt >= dvsr) begin
            tcnt   <= 0;
            s_tick <= tick_en;
        end else begin
            tcnt   <= tcnt + 1;
            s_tick <= 1'b0;
        end
    end

    // Strobe monitor: records every delivered frame, its time, and strobe width.
    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];
    longint     done_t[$];
    int         done_cnt  = 0;
    int         width_err = 0;
    bit         prev_done = 1'b0;

    always @(negedge clk) begin
        if (rx_done_tick) begin
            got_q.push_back({dout, frame_err});
            done_t.push_back(cyc);
            done_cnt <= done_cnt + 1;
        end
        if (rx_done_tick && prev_done) width_err <= width_err + 1;
        prev_done <= rx_done_tick;
    end

    int checks = 0;
    int passes = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            int guard = 0;
            do begin
                @(posedge clk);
                guard++;
            end while (s_tick !== 1'b1 && guard < 5000);
        end
    endtask

    task automatic drive(input logic v);
        #1 rx = v;
    endtask

    // One frame; gate_bit >= 0 freezes the tick stream for 1000 cycles mid that bit.
    task automatic send_frame(input logic [7:0] data, input bit stop_ok, input int gate_bit);
        int cnt0;
        logic [7:0] d0;
        exp_q.push_back({data, ~stop_ok});
        drive(1'b0);
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            drive(data[i]);
            if (i == gate_bit) begin
                wait_ticks(8);
                cnt0 = done_cnt;
                d0   = dout;
                #1 tick_en = 1'b0;
                repeat (1000) @(posedge clk);
                check("gate_no_strobe", 32'(done_cnt), 32'(cnt0));
                check("gate_dout_held", 32'(dout), 32'(d0));
                #1 tick_en = 1'b1;
                wait_ticks(8);
            end else begin
                wait_ticks(16);
            end
        end
        if (stop_ok) begin
            drive(1'b1);
            wait_ticks(16);
        end else begin
            // Low across the stop sample point, released before the next start check.
            drive(1'b0);
            wait_ticks(10);
            drive(1'b1);
            wait_ticks(6);
        end
    endtask

    task automatic expect_next(input string tag);
        int guard = 0;
        logic [8:0] g, e;
        while (got_q.size() == 0 && guard < 2000) begin
            @(posedge clk);
            guard++;
        end
        check({tag, "_arrived"}, 32'(got_q.size() > 0), 32'd1);
        if (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            check({tag, "_dout"}, 32'(g[8:1]), 32'(e[8:1]));
            check({tag, "_ferr"}, 32'(g[0]), 32'(e[0]));
        end
    endtask

    initial begin
        #(20 * 150000);
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int     cnt0;
        logic [7:0] d0;
        longint gap, nom;
        logic [7:0] rb;
        bit     rok;

        repeat (3) @(posedge clk);
        #1;
        check("reset_dout", 32'(dout), 32'd0);
        check("reset_ferr", 32'(frame_err), 32'd0);
        check("reset_done", 32'(rx_done_tick), 32'd0);
        reset = 1'b0;
        repeat (4) @(posedge clk);

        // Single byte at the slow baud setting.
        dvsr = 162;
        wait_ticks(2);
        cnt0 = done_cnt;
        send_frame(8'h55, 1'b1, -1);
        expect_next("single");
        check("single_one_strobe", 32'(done_cnt - cnt0), 32'd1);
        check("single_width", 32'(width_err), 32'd0);

        dvsr = 3;
        wait_ticks(4);

        // Back-to-back without idle gap.
        send_frame(8'hA3, 1'b1, -1);
        send_frame(8'h0F, 1'b1, -1);
        expect_next("b2b_first");
        expect_next("b2b_second");
        gap = done_t[done_t.size() - 1] - done_t[done_t.size() - 2];
        nom = 160 * longint'(dvsr + 1);
        check("b2b_gap", 32'(gap >= nom - (dvsr + 1) && gap <= nom + (dvsr + 1)), 32'd1);

        // Start glitch shorter than half a bit.
        cnt0 = done_cnt;
        d0   = dout;
        drive(1'b0);
        wait_ticks(3);
        drive(1'b1);
        wait_ticks(40);
        check("glitch_no_strobe", 32'(done_cnt), 32'(cnt0));
        check("glitch_dout", 32'(dout), 32'(d0));

        // Framing error, then recovery.
        send_frame(8'hC8, 1'b0, -1);
        expect_next("ferr_frame");
        wait_ticks(16);
        send_frame(8'h21, 1'b1, -1);
        expect_next("ferr_clear");
        send_frame(8'h9C, 1'b0, -1);
        expect_next("ferr_again");
        wait_ticks(16);

        // Reset during data bit 4 of 0xFF.
        cnt0 = done_cnt;
        drive(1'b0);
        wait_ticks(16);
        drive(1'b1);
        wait_ticks(16 * 4 + 8);
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_dout", 32'(dout), 32'd0);
        check("rst_mid_ferr", 32'(frame_err), 32'd0);
        check("rst_mid_done", 32'(rx_done_tick), 32'd0);
        reset = 1'b0;
        wait_ticks(16 * 3 + 8 + 16 + 16);
        check("rst_no_strobe", 32'(done_cnt), 32'(cnt0));
        send_frame(8'h7E, 1'b1, -1);
        expect_next("after_rst");

        // Tick gating mid data bit 3.
        send_frame(8'hB6, 1'b1, 3);
        expect_next("gated");

        // Randomized frames with random stop validity and idle gaps.
        for (int k = 0; k < 8; k++) begin
            rb  = 8'($urandom);
            rok = ($urandom_range(3) != 0);
            send_frame(rb, rok, -1);
            expect_next("rand");
            wait_ticks(rok ? $urandom_range(40) : 16 + $urandom_range(24));
        end

        wait_ticks(40);
        check("no_extra_frames", 32'(got_q.size()), 32'd0);
        check("strobe_width_all", 32'(width_err), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
